// File: rtl/fifo_pkg.sv
// Shared defaults and the skid-occupancy type for the FIFO read streamer.
package fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BURST = 4;

    // Skid occupancy doubles as the buffer's state encoding.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo_rd_stream_skid2.sv
// Two-entry skid buffer (head/tail) with valid/ready on both sides; state is the occupancy.
module skid2
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output occ_t             cnt
);

    // A transfer happens on a side exactly when its valid and ready are both high
    // in the same cycle; in_valid without in_ready drops the word.
    logic [WIDTH-1:0] head, tail, head_nxt, tail_nxt;
    occ_t             cnt_nxt;
    logic             hs, cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            cnt  <= cnt_nxt;
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

    always_comb begin
        hs       = (cnt != OCC_EMPTY) && out_ready;
        in_ready = (cnt != OCC_TWO) || hs;
        cap      = in_valid && in_ready;
        cnt_nxt  = cnt;
        head_nxt = head;
        tail_nxt = tail;
        if (clr) begin
            cnt_nxt = OCC_EMPTY;
        end else begin
            case (cnt)
                OCC_EMPTY: begin
                    if (cap) begin
                        head_nxt = in_data;
                        cnt_nxt  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (cap && !hs) begin
                        tail_nxt = in_data;
                        cnt_nxt  = OCC_TWO;
                    end else if (cap && hs) begin
                        head_nxt = in_data;
                    end else if (hs) begin
                        cnt_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // Tail shifts forward; a coincident capture refills the tail.
                    if (hs) begin
                        head_nxt = tail;
                        if (cap) tail_nxt = in_data;
                        else     cnt_nxt  = OCC_ONE;
                    end
                end
                default: cnt_nxt = OCC_EMPTY;
            endcase
        end
    end

    assign out_valid = (cnt != OCC_EMPTY);
    assign out_data  = head;

endmodule

// File: rtl/fifo_rd_stream.sv
// Streams words from a zero-latency FIFO through a skid pair, adding burst framing and a beat count.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BURST = DEF_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      beat_total
);

    localparam int BW = $clog2(BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    logic          skid_ready;
    logic [BW-1:0] beat;
    logic          hs;
    occ_t          occ;

    skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .in_valid  (fifo_valid && !flush),
        .in_ready  (skid_ready),
        .in_data   (fifo_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt       (occ)
    );

    assign fifo_pop = !fifo_empty && !flush && skid_ready;
    assign hs       = out_valid && out_ready;
    assign out_last = out_valid && (beat == LAST_BEAT);

    // BURST is a power of two, so the beat counter wraps on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            beat_total <= '0;
        end else if (flush) begin
            beat <= '0;
        end else if (hs) begin
            beat       <= beat + 1'b1;
            beat_total <= beat_total + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized checks of fifo_rd_stream against a queue-based reference model.
module tb_fifo_rd_stream;

    localparam int WIDTH = 16;
    localparam int BURST = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [15:0]      beat_total;

    fifo_rd_stream #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .beat_total (beat_total)
    );

    // Upstream zero-latency FIFO: a pop is accepted in the same cycle.
    assign fifo_valid = fifo_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               beat_m;
    int               total_m;
    int               errors;
    int               checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic tick();
        logic             m_hs;
        logic             m_pop;
        logic             dut_pop;
        logic [WIDTH-1:0] word;
        @(negedge clk);
        m_hs  = (exp_q.size() != 0) && out_ready;
        m_pop = (fifo_q.size() != 0) && !flush && (exp_q.size() < 2 || m_hs);
        check("fifo_pop", 32'(fifo_pop), 32'(m_pop));
        dut_pop = fifo_pop;
        word    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        @(posedge clk);
        #1;
        if (dut_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (rst) begin
            exp_q.delete();
            beat_m  = 0;
            total_m = 0;
        end else if (flush) begin
            exp_q.delete();
            beat_m = 0;
        end else begin
            if (m_hs) begin
                void'(exp_q.pop_front());
                beat_m  = (beat_m + 1) % BURST;
                total_m = (total_m + 1) & 16'hFFFF;
            end
            if (m_pop) exp_q.push_back(word);
        end
        refresh();
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (rst) check("out_data_rst", 32'(out_data), 32'h0);
        else if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
        check("out_last", 32'(out_last), 32'((exp_q.size() != 0) && beat_m == BURST - 1));
        check("beat_total", 32'(beat_total), 32'(total_m));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        fifo_q.delete();
        refresh();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic stream_check();
        for (int i = 1; i <= 8; i++) push(16'(i));
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("stream_data", 32'(out_data), 32'(i + 1));
            check("stream_last", 32'(out_last), 32'(((i + 1) % 4) == 0));
            tick();
        end
        check("stream_total", 32'(beat_total), 32'd8);
        check("stream_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        beat_m    = 0;
        total_m   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        refresh();

        // Reset state
        do_reset();
        check("rst_beat_total", 32'(beat_total), 32'd0);

        // Empty FIFO, then a single word
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        push(16'h005A);
        #1;
        check("single_pop", 32'(fifo_pop), 32'd1);
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h5A);
        tick();

        // Streaming
        do_reset();
        stream_check();

        // Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) push(16'hA0 + 16'(i));
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("bp_cnt", 32'(dut.u_skid.cnt), 32'd2);
        check("bp_pop", 32'(fifo_pop), 32'd0);
        check("bp_data", 32'(out_data), 32'hA0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_order", 32'(out_data), 32'hA0 + 32'(i));
            tick();
        end
        check("bp_total", 32'(beat_total), 32'd4);

        // Alternating ready
        do_reset();
        for (int i = 0; i < 12; i++) push(16'hC0 + 16'(i));
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 2) == 0;
            tick();
        end
        check("alt_total", 32'(beat_total), 32'd12);

        // Flush mid-burst
        do_reset();
        for (int i = 0; i < 8; i++) push(16'hF0 + 16'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        tick();
        check("fl_cnt", 32'(dut.u_skid.cnt), 32'd2);
        check("fl_total_pre", 32'(beat_total), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_beat", 32'(dut.beat), 32'd0);
        check("fl_total", 32'(beat_total), 32'd2);
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("fl_last", 32'(out_last), 32'(i == 3));
            tick();
        end

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 4; i++) push(16'hB0 + 16'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("ar_beat", 32'(dut.beat), 32'd3);
        check("ar_cnt", 32'(dut.u_skid.cnt), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_total", 32'(beat_total), 32'd0);
        check("ar_last", 32'(out_last), 32'd0);
        exp_q.delete();
        beat_m  = 0;
        total_m = 0;
        tick();
        rst = 1'b0;
        stream_check();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) push(16'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
